uart_transmitter: RTL and testbench
===================================

// Module: uart_transmitter
// PURPOSE
//  Serialises bytes that the core writes to the UART TX MMIO register into 8N1 frames on the FPGA TX pin.
//  It is the responder end of the core's UART_Write_valid handshake; data_in_ready is read back through the UART control register.
//  It sits between the memory-mapped I/O decode and the board serial pin.
// PARAMETERS
//  CLOCK_FREQ   125_000_000  core clock frequency in Hz
//  BAUD_RATE    115_200      line rate in bit/s
//  (local) SYMBOL_EDGE_LIMIT = CLOCK_FREQ/BAUD_RATE (truncating); must be >= 2 (checked at elaboration with $error)
// PORTS
//  clk            in   1  core clock; all logic on posedge
//  rst_n          in   1  asynchronous, active-low reset
//  data_in        in   8  byte to send; sampled only on acceptance
//  data_in_valid  in   1  core offers data_in (driven from UART_Write_valid)
//  data_in_ready  out  1  transmitter can accept a byte this cycle
//  serial_out     out  1  TX line; idles high
// BEHAVIOUR
//  Reset (rst_n=0, async): serial_out=1, data_in_ready=1, state=IDLE, counters=0, shift reg=0. Applies mid-frame: the frame is dropped, the line returns high immediately, and no partial retransmission follows.
//  Handshake: transfer occurs on a posedge with data_in_valid && data_in_ready. data_in is latched into the shift register at that edge.
//  data_in_ready is registered: it drops the cycle after acceptance and stays low for the whole frame.
//  data_in_ready reasserts in the cycle after the last stop-bit cycle. data_in_valid while ready=0 is ignored (no queueing).
//  FSM: IDLE -> START -> DATA -> STOP -> IDLE (PARITY is inserted between DATA and STOP when enabled).
//   IDLE : serial_out=1; on acceptance go to START.
//   START: serial_out=0 for SYMBOL_EDGE_LIMIT cycles, beginning the cycle after acceptance.
//   DATA : 8 symbols, LSB first, each SYMBOL_EDGE_LIMIT cycles; bit counter 0..7 in 3 bits.
//   STOP : serial_out=1 for SYMBOL_EDGE_LIMIT cycles, then IDLE with ready=1.
//  Symbol timing: cycle counter of width $clog2(SYMBOL_EDGE_LIMIT), counting 0..SYMBOL_EDGE_LIMIT-1 and wrapping to 0 at the symbol boundary. The counter is held at 0 in IDLE.
//  serial_out is driven from a flop (glitch-free); latency acceptance->start bit = 1 cycle.
//  Frame length = 10*SYMBOL_EDGE_LIMIT cycles (11* with parity).
//  Back-to-back: if valid is held high, the next byte is accepted on the first ready cycle.
//   The line then stays high exactly 1 cycle between the stop bit and the next start bit.
//  data_in changes after acceptance do not affect the frame in flight.
// CONFIGURATION
//  `define UART_TX_PARITY_EN: adds a PARITY state after DATA.
//   In PARITY, serial_out = ^data for one symbol (even parity); frame = 11 symbols.
//  Without the macro: 8N1 only, no PARITY state or parity logic synthesised.
// STRUCTURE
//  Shared package uart_pkg (header uart_defines.vh):
//   - FSM state encodings (IDLE, START, DATA, PARITY, STOP), 3-bit;
//   - UART_DATA_W = 8;
//   - UART_STOP_LEVEL = 1'b1, UART_START_LEVEL = 1'b0.
//   The future uart_receiver shares this package.
//  Sub-module: uart_baud_counter (params CLOCK_FREQ, BAUD_RATE; in clk, rst_n, run; out symbol_done).
//   symbol_done pulses on the last cycle of each symbol. uart_receiver reuses it.
// TESTING
//  Use CLOCK_FREQ=1_000_000, BAUD_RATE=100_000 (10 cycles/symbol) in all scenarios.
//  1. Reset: hold rst_n=0 for 5 cycles -> serial_out=1, data_in_ready=1; line stays high 50 idle cycles.
//  2. Single byte: send 0xA5 -> line 0,1,0,1,0,0,1,0,1,1 (start, LSB-first, stop), 10 cycles each.
//     Start begins 1 cycle after acceptance; ready is low for exactly 100 cycles.
//  3. Back-to-back with valid held: send 0x00 then 0xFF -> two complete frames separated by 1 high cycle.
//     The second byte is accepted on the first cycle ready returns to 1.
//  4. Ignore while busy: during 0x3C, pulse valid with 0x81 at cycle 40 -> not accepted.
//     Frame stays 0x3C; data_in change at cycle 20 has no effect.
//  5. Reset mid-frame: assert rst_n=0 during bit 4 of 0x55 -> serial_out=1 asynchronously, ready=1 after release.
//     Then send 0x12 -> correct frame.
//  6. UART_TX_PARITY_EN: 0xA5 -> parity symbol 0, 110-cycle frame; 0x01 -> parity symbol 1.
//     Without the macro, 0x01 frame length is 100 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and the planned receiver.
// The UART_TX_PARITY_EN macro adds the PARITY state; the encoding is reserved either way.
package uart_pkg;

    localparam int   UART_DATA_W      = 8;
    localparam logic UART_STOP_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_baud_counter.sv
// Symbol timer: counts clock cycles within one UART symbol while run is high.
// symbol_done marks the final cycle of each symbol; the count rests at 0 when idle.
module uart_baud_counter #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic symbol_done
);

    localparam int SYMBOL_EDGE_LIMIT = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W = (SYMBOL_EDGE_LIMIT < 2) ? 1 : $clog2(SYMBOL_EDGE_LIMIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SYMBOL_EDGE_LIMIT - 1);

    if (SYMBOL_EDGE_LIMIT < 2) begin : g_bad_rate
        $error("uart_baud_counter: CLOCK_FREQ/BAUD_RATE must be at least 2");
    end

    logic [CNT_W-1:0] count;

    assign symbol_done = run && (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!run || symbol_done) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter behind a valid/ready byte handshake.
// Define UART_TX_PARITY_EN to insert an even-parity symbol between data and stop.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [UART_DATA_W-1:0] data_in,
    input  logic                   data_in_valid,
    output logic                   data_in_ready,
    output logic                   serial_out
);

    uart_state_t            state;
    logic [UART_DATA_W-1:0] shift;
    logic [2:0]             bit_idx;
    logic                   symbol_done;
    logic                   run;
`ifdef UART_TX_PARITY_EN
    logic                   parity_bit;
`endif

    assign run = (state != IDLE);

    uart_baud_counter #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE)
    ) u_baud (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .symbol_done (symbol_done)
    );

    // serial_out always holds the level of the symbol currently on the line;
    // shift[0] is the bit being sent, so the next level is taken from shift[1].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            serial_out    <= UART_STOP_LEVEL;
            data_in_ready <= 1'b1;
            shift         <= '0;
            bit_idx       <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (data_in_valid && data_in_ready) begin
                        shift         <= data_in;
                        bit_idx       <= '0;
                        state         <= START;
                        serial_out    <= UART_START_LEVEL;
                        data_in_ready <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        parity_bit    <= ^data_in;
`endif
                    end
                end
                START: begin
                    if (symbol_done) begin
                        state      <= DATA;
                        serial_out <= shift[0];
                    end
                end
                DATA: begin
                    if (symbol_done) begin
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state      <= PARITY;
                            serial_out <= parity_bit;
`else
                            state      <= STOP;
                            serial_out <= UART_STOP_LEVEL;
`endif
                        end else begin
                            bit_idx    <= bit_idx + 3'd1;
                            shift      <= shift >> 1;
                            serial_out <= shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (symbol_done) begin
                        state      <= STOP;
                        serial_out <= UART_STOP_LEVEL;
                    end
                end
`endif
                STOP: begin
                    if (symbol_done) begin
                        state         <= IDLE;
                        data_in_ready <= 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    serial_out    <= UART_STOP_LEVEL;
                    data_in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter at 10 clock cycles per symbol.
// Honours UART_TX_PARITY_EN when the bundle is built with that macro.
module tb_uart_transmitter;

    localparam int SYM = 10;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_SYMS = 11;
`else
    localparam int FRAME_SYMS = 10;
`endif
    localparam int FRAME_CYCLES = FRAME_SYMS * SYM;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_in_valid = 1'b0;
    logic       data_in_ready;
    logic       serial_out;

    int total = 0;
    int passed = 0;
    int failed = 0;

    uart_transmitter #(
        .CLOCK_FREQ (1_000_000),
        .BAUD_RATE  (100_000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .serial_out    (serial_out)
    );

    always #5 clk = ~clk;

    // Reference line level k cycles into a frame, built from the symbol order.
    function automatic logic expected_bit(input logic [7:0] b, input int k);
        int sym;
        sym = k / SYM;
        if (sym == 0) return 1'b0;
        if (sym <= 8) return b[sym-1];
`ifdef UART_TX_PARITY_EN
        if (sym == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        total++;
        assert (observed === expected) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Offers a byte from an idle line; it is accepted on the next posedge.
    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        checkOutput("idle_ready", {7'd0, data_in_ready}, 8'd1);
        checkOutput("idle_line", {7'd0, serial_out}, 8'd1);
        data_in       = b;
        data_in_valid = 1'b1;
    endtask

    // Follows a frame from its first cycle; optional input pokes at chosen cycles.
    task automatic watchFrame(input logic [7:0] b, input logic c0_valid, input logic [7:0] c0_data,
                              input int p1, input logic [7:0] p1_data,
                              input int p2, input logic [7:0] p2_data, input int stop_at);
        for (int k = 0; k < FRAME_CYCLES; k++) begin
            if (k == stop_at) return;
            @(negedge clk);
            checkOutput($sformatf("line_%02h_c%0d", b, k), {7'd0, serial_out}, {7'd0, expected_bit(b, k)});
            checkOutput($sformatf("busy_%02h_c%0d", b, k), {7'd0, data_in_ready}, 8'd0);
            if (k == 0) begin
                data_in_valid = c0_valid;
                data_in       = c0_data;
            end
            if (k == p1) data_in = p1_data;
            if (k == p2) begin
                data_in       = p2_data;
                data_in_valid = 1'b1;
            end else if (p2 >= 0 && k == p2 + 1) begin
                data_in_valid = 1'b0;
            end
        end
        @(negedge clk);
        checkOutput($sformatf("ready_back_%02h", b), {7'd0, data_in_ready}, 8'd1);
        checkOutput($sformatf("gap_line_%02h", b), {7'd0, serial_out}, 8'd1);
    endtask

    task automatic idleCycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput(tag, {7'd0, serial_out}, 8'd1);
            checkOutput({tag, "_ready"}, {7'd0, data_in_ready}, 8'd1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] r0, r1, r2;

        $display("[TB] reset");
        repeat (5) @(negedge clk);
        checkOutput("reset_line", {7'd0, serial_out}, 8'd1);
        checkOutput("reset_ready", {7'd0, data_in_ready}, 8'd1);
        rst_n = 1'b1;
        idleCycles(50, "idle50");

        $display("[TB] single byte 0xA5");
        applyStimulus(8'hA5);
        watchFrame(8'hA5, 1'b0, 8'hA5, -1, 8'h00, -1, 8'h00, -1);

        $display("[TB] back-to-back 0x00 then 0xFF");
        applyStimulus(8'h00);
        watchFrame(8'h00, 1'b1, 8'hFF, -1, 8'h00, -1, 8'h00, -1);
        watchFrame(8'hFF, 1'b0, 8'hFF, -1, 8'h00, -1, 8'h00, -1);

        $display("[TB] ignore while busy 0x3C");
        r0 = 8'($urandom);
        applyStimulus(8'h3C);
        watchFrame(8'h3C, 1'b0, 8'h3C, 20, r0, 40, 8'h81, -1);
        idleCycles(20, "no_queue");

        $display("[TB] reset mid-frame 0x55");
        applyStimulus(8'h55);
        watchFrame(8'h55, 1'b0, 8'h55, -1, 8'h00, -1, 8'h00, 55);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_line", {7'd0, serial_out}, 8'd1);
        checkOutput("async_ready", {7'd0, data_in_ready}, 8'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idleCycles(30, "post_reset");
        applyStimulus(8'h12);
        watchFrame(8'h12, 1'b0, 8'h12, -1, 8'h00, -1, 8'h00, -1);

        $display("[TB] parity-sensitive byte 0x01");
        applyStimulus(8'h01);
        watchFrame(8'h01, 1'b0, 8'h01, -1, 8'h00, -1, 8'h00, -1);

        $display("[TB] random bytes");
        for (int i = 0; i < 4; i++) begin
            r0 = 8'($urandom);
            applyStimulus(r0);
            watchFrame(r0, 1'b0, 8'($urandom), -1, 8'h00, -1, 8'h00, -1);
        end
        r0 = 8'($urandom);
        r1 = 8'($urandom);
        r2 = 8'($urandom);
        applyStimulus(r0);
        watchFrame(r0, 1'b1, r1, -1, 8'h00, -1, 8'h00, -1);
        watchFrame(r1, 1'b1, r2, -1, 8'h00, -1, 8'h00, -1);
        watchFrame(r2, 1'b0, 8'h00, -1, 8'h00, -1, 8'h00, -1);
        idleCycles(5, "final_idle");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
